// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode, ALU select and immediate helpers
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_SEL_ADD    = 4'd0;
  localparam logic [3:0] ALU_SEL_SUB    = 4'd1;
  localparam logic [3:0] ALU_SEL_SLL    = 4'd2;
  localparam logic [3:0] ALU_SEL_SLT    = 4'd3;
  localparam logic [3:0] ALU_SEL_SLTU   = 4'd4;
  localparam logic [3:0] ALU_SEL_XOR    = 4'd5;
  localparam logic [3:0] ALU_SEL_SRL    = 4'd6;
  localparam logic [3:0] ALU_SEL_SRA    = 4'd7;
  localparam logic [3:0] ALU_SEL_OR     = 4'd8;
  localparam logic [3:0] ALU_SEL_AND    = 4'd9;
  localparam logic [3:0] ALU_SEL_PASS_B = 4'd10;

  typedef enum logic [1:0] {A_ZERO, A_RS1, A_PC} a_src_e;
  typedef enum logic [2:0] {B_ZERO, B_RS2, B_IMM_I, B_SHAMT, B_IMM_U} b_src_e;

  typedef struct packed {
    logic [3:0] alu_sel;
    a_src_e     a_src;
    b_src_e     b_src;
    logic       use_rs1;
    logic       use_rs2;
    logic       illegal;
  } decode_t;

  function automatic logic [31:0] imm_i(input logic [11:0] f);
    return {{20{f[11]}}, f};
  endfunction

  function automatic logic [31:0] imm_u(input logic [19:0] f);
    return {f, 12'b0};
  endfunction

  function automatic logic [31:0] imm_shamt(input logic [4:0] f);
    return {27'b0, f};
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - two async read ports, one sync write port, x0 hardwired
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wdata;
    end
  end

  // Write-through: a same-cycle write is visible on the read ports.
  always_comb begin
    rdata1 = mem[ra1];
    if (ra1 == '0)
      rdata1 = '0;
    else if (we && wa == ra1)
      rdata1 = wdata;
  end

  always_comb begin
    rdata2 = mem[ra2];
    if (ra2 == '0)
      rdata2 = '0;
    else if (we && wa == ra2)
      rdata2 = wdata;
  end

endmodule

// File: rtl/id_ex_issue.sv
// rtl/id_ex_issue.sv - RV32I decode/issue stage with busy-bit scoreboard
module id_ex_issue
  import rv32i_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [31:0]     if_pc,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_alu_sel,
  output logic [4:0]      ex_rd,
  output logic            ex_we,
  output logic [31:0]     ex_pc,
  output logic            ex_illegal,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign funct3 = if_instr[14:12];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign funct7 = if_instr[31:25];

  logic [XLEN-1:0] rs1_data, rs2_data;

  regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS), .AW(5)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .ra1    (rs1),
    .rdata1 (rs1_data),
    .ra2    (rs2),
    .rdata2 (rs2_data),
    .we     (wb_we),
    .wa     (wb_rd),
    .wdata  (wb_data)
  );

  decode_t dec;

  always_comb begin
    dec = '{alu_sel: ALU_SEL_ADD, a_src: A_ZERO, b_src: B_ZERO,
            use_rs1: 1'b0, use_rs2: 1'b0, illegal: 1'b1};
    case (opcode)
      OPC_OP: begin
        dec.use_rs1 = 1'b1;
        dec.use_rs2 = 1'b1;
        dec.a_src   = A_RS1;
        dec.b_src   = B_RS2;
        if (funct7 == F7_BASE) begin
          dec.illegal = 1'b0;
          case (funct3)
            3'd0:    dec.alu_sel = ALU_SEL_ADD;
            3'd1:    dec.alu_sel = ALU_SEL_SLL;
            3'd2:    dec.alu_sel = ALU_SEL_SLT;
            3'd3:    dec.alu_sel = ALU_SEL_SLTU;
            3'd4:    dec.alu_sel = ALU_SEL_XOR;
            3'd5:    dec.alu_sel = ALU_SEL_SRL;
            3'd6:    dec.alu_sel = ALU_SEL_OR;
            default: dec.alu_sel = ALU_SEL_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
          dec.illegal = 1'b0;
          dec.alu_sel = ALU_SEL_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
          dec.illegal = 1'b0;
          dec.alu_sel = ALU_SEL_SRA;
        end
      end
      OPC_OP_IMM: begin
        dec.use_rs1 = 1'b1;
        dec.a_src   = A_RS1;
        dec.b_src   = B_IMM_I;
        dec.illegal = 1'b0;
        case (funct3)
          3'd0: dec.alu_sel = ALU_SEL_ADD;
          3'd2: dec.alu_sel = ALU_SEL_SLT;
          3'd3: dec.alu_sel = ALU_SEL_SLTU;
          3'd4: dec.alu_sel = ALU_SEL_XOR;
          3'd6: dec.alu_sel = ALU_SEL_OR;
          3'd7: dec.alu_sel = ALU_SEL_AND;
          3'd1: begin
            dec.b_src   = B_SHAMT;
            dec.alu_sel = ALU_SEL_SLL;
            dec.illegal = (funct7 != F7_BASE);
          end
          default: begin
            dec.b_src   = B_SHAMT;
            dec.alu_sel = (funct7 == F7_ALT) ? ALU_SEL_SRA : ALU_SEL_SRL;
            dec.illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
        endcase
      end
      OPC_LUI: begin
        dec.b_src   = B_IMM_U;
        dec.alu_sel = ALU_SEL_PASS_B;
        dec.illegal = 1'b0;
      end
      OPC_AUIPC: begin
        dec.a_src   = A_PC;
        dec.b_src   = B_IMM_U;
        dec.alu_sel = ALU_SEL_ADD;
        dec.illegal = 1'b0;
      end
      default: ;
    endcase
    // Illegal instructions issue as a harmless ADD of zeros.
    if (dec.illegal) begin
      dec.alu_sel = ALU_SEL_ADD;
      dec.a_src   = A_ZERO;
      dec.b_src   = B_ZERO;
    end
  end

  logic [XLEN-1:0] op_a, op_b;

  always_comb begin
    case (dec.a_src)
      A_RS1:   op_a = rs1_data;
      A_PC:    op_a = XLEN'(if_pc);
      default: op_a = '0;
    endcase
    case (dec.b_src)
      B_RS2:   op_b = rs2_data;
      B_IMM_I: op_b = XLEN'(imm_i(if_instr[31:20]));
      B_SHAMT: op_b = XLEN'(imm_shamt(if_instr[24:20]));
      B_IMM_U: op_b = XLEN'(imm_u(if_instr[31:12]));
      default: op_b = '0;
    endcase
  end

  logic [NREGS-1:0] busy, busy_next;
  logic             dec_we, hazard, xfer;

  assign dec_we = !dec.illegal && (rd != 5'd0);

  // A writeback landing on a busy source this cycle resolves the hazard via bypass.
  assign hazard = (dec.use_rs1 && rs1 != 5'd0 && busy[rs1] && !(wb_we && wb_rd == rs1)) ||
                  (dec.use_rs2 && rs2 != 5'd0 && busy[rs2] && !(wb_we && wb_rd == rs2));

  assign if_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign xfer     = if_valid && if_ready;

  always_comb begin
    busy_next = busy;
    if (wb_we)
      busy_next[wb_rd] = 1'b0;
    if (flush && ex_valid && !ex_ready && ex_we)
      busy_next[ex_rd] = 1'b0;
    // A new producer wins over a same-cycle clear of the same register.
    if (xfer && dec_we)
      busy_next[rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_alu_sel <= ALU_SEL_ADD;
      ex_rd      <= 5'd0;
      ex_we      <= 1'b0;
      ex_pc      <= RESET_PC;
      ex_illegal <= 1'b0;
    end else if (xfer) begin
      ex_valid   <= 1'b1;
      ex_a       <= op_a;
      ex_b       <= op_b;
      ex_alu_sel <= dec.alu_sel;
      ex_rd      <= rd;
      ex_we      <= dec_we;
      ex_pc      <= if_pc;
      ex_illegal <= dec.illegal;
    end else if (ex_ready || flush) begin
      ex_valid <= 1'b0;
    end
  end

endmodule
